// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Latency: n/a (constants only).
// Backpressure: n/a.
package rf_write_arbiter_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int REG_ZERO = 0;
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter; grant is combinational, pointer updates on grant.
// Latency: 0 cycles from valid to grant.
// Backpressure: hold or reset suppresses all grants; pointer then holds.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       hold_i,
  input  logic [1:0] valid_i,
  output logic [1:0] gnt_o
);
  import rf_write_arbiter_pkg::*;

  // Index of the most recent winner; reset to 1 so requester 0 wins first.
  logic last_grant_q;
  logic last_grant_d;

  // Grant selection: sole requester wins, contention goes to the non-last winner.
  always_comb begin
    gnt_o        = 2'b00;
    last_grant_d = last_grant_q;
    if (!rst_i && !hold_i) begin
      case (valid_i)
        2'b01:   gnt_o[REQ_ALU]  = 1'b1;
        2'b10:   gnt_o[REQ_LOAD] = 1'b1;
        2'b11: begin
          if (last_grant_q) gnt_o[REQ_ALU]  = 1'b1;
          else              gnt_o[REQ_LOAD] = 1'b1;
        end
        default: gnt_o = 2'b00;
      endcase
    end
    // A grant always coincides with a transfer, since grant implies valid.
    if (gnt_o[REQ_LOAD])     last_grant_d = 1'b1;
    else if (gnt_o[REQ_ALU]) last_grant_d = 1'b0;
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst_i) last_grant_q <= 1'b1;
    else       last_grant_q <= last_grant_d;
  end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port between ALU (0) and load (1) writeback, round-robin.
// Latency: 1 cycle from accept to rf_we; writes to register 0 are dropped.
// Backpressure: ready is combinational; hold/rst deassert both readies, output stage never stalls.
module rf_write_arbiter #(
  parameter int DATA_W = rf_write_arbiter_pkg::DATA_W,
  parameter int ADDR_W = rf_write_arbiter_pkg::ADDR_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wd,
  output logic              zero_drop,
  output logic [CNT_W-1:0]  acc_cnt0,
  output logic [CNT_W-1:0]  acc_cnt1
);
  import rf_write_arbiter_pkg::*;

  logic [1:0]        gnt;
  logic              xfer0;
  logic              xfer1;
  logic              xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_zero;

  logic              rf_we_q,     rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q,   rf_addr_d;
  logic [DATA_W-1:0] rf_wd_q,     rf_wd_d;
  logic              zero_drop_q, zero_drop_d;
  logic [CNT_W-1:0]  cnt0_q,      cnt0_d;
  logic [CNT_W-1:0]  cnt1_q,      cnt1_d;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_i   (rst),
    .hold_i  (hold),
    .valid_i ({req1_valid, req0_valid}),
    .gnt_o   (gnt)
  );

  assign req0_ready = gnt[REQ_ALU];
  assign req1_ready = gnt[REQ_LOAD];
  assign xfer0      = req0_valid & req0_ready;
  assign xfer1      = req1_valid & req1_ready;
  assign xfer       = xfer0 | xfer1;

  // Winner's payload mux and register-zero detection.
  always_comb begin
    sel_addr = req0_addr;
    sel_data = req0_data;
    if (xfer1) begin
      sel_addr = req1_addr;
      sel_data = req1_data;
    end
    sel_zero = (sel_addr == ADDR_W'(REG_ZERO));
  end

  // Output stage next state: address/data only move on a non-zero write.
  always_comb begin
    rf_we_d     = 1'b0;
    zero_drop_d = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_wd_d     = rf_wd_q;
    if (xfer) begin
      if (sel_zero) begin
        zero_drop_d = 1'b1;
      end else begin
        rf_we_d   = 1'b1;
        rf_addr_d = sel_addr;
        rf_wd_d   = sel_data;
      end
    end
  end

  // Saturating debug counters; zero-register drops still count as accepts.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (xfer0 && (cnt0_q != {CNT_W{1'b1}})) cnt0_d = cnt0_q + 1'b1;
    if (xfer1 && (cnt1_q != {CNT_W{1'b1}})) cnt1_d = cnt1_q + 1'b1;
  end

  // State registers; reset also discards any write held in the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wd_q     <= '0;
      zero_drop_q <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_wd_q     <= rf_wd_d;
      zero_drop_q <= zero_drop_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_addr   = rf_addr_q;
  assign rf_wd     = rf_wd_q;
  assign zero_drop = zero_drop_q;
  assign acc_cnt0  = cnt0_q;
  assign acc_cnt1  = cnt1_q;
endmodule
